coinc_event_counter_bank: RTL
=============================

// Module: coinc_event_counter_bank
// PURPOSE
// Multi-channel successor to the single-channel pixel event counter. Counts qualified
// events on NUM_CH asynchronous X inputs, each gated by a shared Y strobe. A read request
// snapshots all channels at once into shadow registers read over a select/data port.
// Sits between the detector front end and the readout/bus interface.
// PARAMETERS
// NUM_CH       4  number of X channels (1..16)
// CNT_W       32  counter / snapshot width (8..32)
// SYNC_STAGES  2  synchroniser depth on xChannel, yChannel, readDataClock (2..4)
// EDGE_MODE    0  0 = rising, 1 = falling, 2 = both edges of X count
// SATURATE     0  0 = counter wraps at 2^CNT_W, 1 = holds at all-ones
// CLR_ON_SNAP  0  1 = counters and ovf cleared by each snapshot
// PORTS
// refClock       in   1              system clock; all logic on its rising edge
// rstCounter     in   1              asynchronous, active-high reset
// xChannel       in   NUM_CH         async event inputs, one per channel
// yChannel       in   1              async coincidence gate, shared by all channels
// enCounter      in   1              active-high count enable, synchronous to refClock
// readDataClock  in   1              async read request; its rising edge triggers a snapshot
// rdSel          in   clog2(NUM_CH)  shadow channel select, max(1)
// rdData         out  CNT_W          shadow value of channel rdSel, registered
// rdOvf          out  1              shadow overflow flag of channel rdSel, registered
// snapValid      out  1              one-cycle pulse: snapshot completed
// BEHAVIOUR
// - Reset clears all sync chains, edge history, counters, ovf, shadows, rdData, rdOvf,
//   snapValid and the arm counter to 0. A reset mid-count discards everything at once.
// - Arming: edge detection is suppressed for SYNC_STAGES+1 cycles after reset release,
//   so inputs already high at release give no spurious count or snapshot.
// - Each input passes through SYNC_STAGES flops, plus one history flop per X and read.
// - Event on ch i: edge per EDGE_MODE on sync x[i] and sync y == 1, enCounter == 1, armed.
// - Latency: the first refClock edge k that samples the new X level (Y already high)
//   gives a counter update at edge k+SYNC_STAGES. Example: SYNC_STAGES=2 gives k+2.
// - Y is sampled through the same chain depth as X, so the two stay aligned. A Y level
//   is judged at the same synchronised cycle as the X edge.
// - X pulses shorter than 1 refClock period may be missed. This is a spec'd limitation.
// - Overflow: an increment from all-ones sets ovf[i] (sticky). SATURATE=0 wraps to 0;
//   SATURATE=1 holds all-ones.
// - Snapshot: a rising edge of sync readDataClock (armed) copies every counter and ovf
//   into the shadows on one edge s. snapValid = 1 for the cycle after s.
// - Snapshot coincident with an event on ch i: the shadow gets the pre-increment value.
//   With CLR_ON_SNAP=1 the counter becomes 1, not 0, so no event is lost.
//   ovf clears except when that same increment overflows.
// - Read port: each edge rdData <= shadow[rdSel] and rdOvf <= shadowOvf[rdSel]
//   (1-cycle latency). rdSel >= NUM_CH returns 0.
// - enCounter only gates counting; snapshots and the read port run regardless.
// - Widths: counters are CNT_W bits unsigned with no internal carry beyond CNT_W.
// TESTING
// 1. Reset, NUM_CH=4, y=1, en=1, 10 X rising pulses on ch2 (4 clk wide), snapshot, rdSel=2
//    -> rdData=10, rdOvf=0, other channels read 0, snapValid one 1-cycle pulse.
// 2. y=0 during 5 X pulses then y=1 for 3 pulses -> count 3; en=0 with 4 more -> still 3.
// 3. CNT_W=8: 257 pulses -> SATURATE=0 gives 1 with ovf=1; SATURATE=1 gives 255 with ovf=1.
// 4. CLR_ON_SNAP=1: 6 pulses, snapshot at the same cycle as the 7th event -> shadow=6,
//    live=1; next snapshot after 2 more pulses -> 3.
// 5. X and readDataClock held high across reset release -> no count, no snapValid.
//    Assert rstCounter mid-count -> rdData=0 next cycle.
// 6. EDGE_MODE=2, 4 full X pulses -> 8. EDGE_MODE=1 -> 4 counts, each falling-edge timed.

Source files
------------

// File: rtl/coinc_event_counter_bank.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : coinc_event_counter_bank                                    |
// | Description : X/Y coincidence event counters with snapshot shadow bank    |
// |               and registered select/data read port.                       |
// | Revision    : 1.0 - initial multi-channel release                         |
// +--------------------------------------------------------------------------+
module coinc_event_counter_bank #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0,
    parameter int SATURATE    = 0,
    parameter int CLR_ON_SNAP = 0
) (
    input  logic                                                refClock,
    input  logic                                                rstCounter,
    input  logic [NUM_CH-1:0]                                   xChannel,
    input  logic                                                yChannel,
    input  logic                                                enCounter,
    input  logic                                                readDataClock,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]      rdSel,
    output logic [CNT_W-1:0]                                    rdData,
    output logic                                                rdOvf,
    output logic                                                snapValid
);

    localparam int       c_SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int       c_IN_W     = NUM_CH + 2;
    localparam logic [2:0] c_ARM_DONE = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][c_IN_W-1:0] r_sync;
    logic [NUM_CH-1:0]                  r_xHist;
    logic                               r_rdHist;
    logic [2:0]                         r_armCnt;

    logic [c_IN_W-1:0] w_syncIn;
    logic [NUM_CH-1:0] w_xS;
    logic              w_yS;
    logic              w_rdS;
    logic              w_armed;
    logic              w_snap;
    logic [NUM_CH-1:0] w_xEdge;
    logic [NUM_CH-1:0] w_inc;

    logic [CNT_W-1:0]  w_shadow    [NUM_CH];
    logic              w_shadowOvf [NUM_CH];
    logic [CNT_W-1:0]  w_rdDataNext;
    logic              w_rdOvfNext;

    assign w_syncIn = {readDataClock, yChannel, xChannel};
    assign w_xS     = r_sync[SYNC_STAGES-1][NUM_CH-1:0];
    assign w_yS     = r_sync[SYNC_STAGES-1][NUM_CH];
    assign w_rdS    = r_sync[SYNC_STAGES-1][NUM_CH+1];

    // History keeps tracking during arming so levels present at reset release
    // are treated as already seen, never as fresh edges.
    always_ff @(posedge refClock or posedge rstCounter) begin
        if (rstCounter) begin
            r_sync   <= '0;
            r_xHist  <= '0;
            r_rdHist <= 1'b0;
            r_armCnt <= 3'd0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], w_syncIn};
            r_xHist  <= w_xS;
            r_rdHist <= w_rdS;
            if (r_armCnt != c_ARM_DONE) begin
                r_armCnt <= r_armCnt + 3'd1;
            end
        end
    end

    assign w_armed = (r_armCnt == c_ARM_DONE);
    assign w_snap  = w_armed & w_rdS & ~r_rdHist;
    assign w_xEdge = (EDGE_MODE == 1) ? (~w_xS & r_xHist) :
                     (EDGE_MODE == 2) ? (w_xS ^ r_xHist)  :
                                        (w_xS & ~r_xHist);
    assign w_inc   = w_xEdge & {NUM_CH{w_armed & w_yS & enCounter}};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;
            logic             r_ovf;
            logic [CNT_W-1:0] r_shadow;
            logic             r_shadowOvf;
            logic             w_full;

            assign w_full = &r_cnt;

            // On a coincident snapshot the shadow takes the pre-increment value
            // and a clearing counter restarts at the event it just absorbed.
            always_ff @(posedge refClock or posedge rstCounter) begin
                if (rstCounter) begin
                    r_cnt       <= '0;
                    r_ovf       <= 1'b0;
                    r_shadow    <= '0;
                    r_shadowOvf <= 1'b0;
                end else begin
                    if (w_snap) begin
                        r_shadow    <= r_cnt;
                        r_shadowOvf <= r_ovf;
                    end
                    if ((CLR_ON_SNAP != 0) && w_snap) begin
                        r_cnt <= w_inc[gi] ? CNT_W'(1) : '0;
                        r_ovf <= w_inc[gi] & w_full;
                    end else if (w_inc[gi]) begin
                        if (w_full) begin
                            r_ovf <= 1'b1;
                            r_cnt <= (SATURATE != 0) ? r_cnt : '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
            end

            assign w_shadow[gi]    = r_shadow;
            assign w_shadowOvf[gi] = r_shadowOvf;
        end
    endgenerate

    always_comb begin
        w_rdDataNext = '0;
        w_rdOvfNext  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rdSel == c_SEL_W'(i)) begin
                w_rdDataNext = w_shadow[i];
                w_rdOvfNext  = w_shadowOvf[i];
            end
        end
    end

    always_ff @(posedge refClock or posedge rstCounter) begin
        if (rstCounter) begin
            rdData    <= '0;
            rdOvf     <= 1'b0;
            snapValid <= 1'b0;
        end else begin
            rdData    <= w_rdDataNext;
            rdOvf     <= w_rdOvfNext;
            snapValid <= w_snap;
        end
    end

endmodule
`default_nettype wire
